fwd_sel_unit: RTL and testbench



---
 rtl/fwd_sel_unit.sv | 129 ++++++++++++
 tb/tb_fwd_sel_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fwd_sel_unit.sv
// EX-stage operand-forwarding select and load-use hazard controller.
// Shadows the ID/EX, EX/MEM and MEM/WB pipeline slots to drive the 3:1 forwarding muxes.
module fwd_sel_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } ex_slot_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
  } wr_slot_t;

  ex_slot_t         r_ex;
  wr_slot_t         r_mem;
  wr_slot_t         r_wb;
  logic [CNT_W-1:0] r_stall_count;

  ex_slot_t         w_ex_next;
  fwd_sel_e         w_fwd_a;
  fwd_sel_e         w_fwd_b;
  logic             w_rs1_hit;
  logic             w_rs2_hit;
  logic             w_load_hazard;

  // A slot is a forwarding source only if it really writes a non-zero register.
  function automatic logic slot_supplies(input wr_slot_t slot, input logic [REG_AW-1:0] src);
    return slot.valid && slot.reg_write && (slot.rd != '0) && (slot.rd == src);
  endfunction

  // MEM is checked first so the youngest producer wins when both older slots match.
  function automatic fwd_sel_e pick_src(input logic ex_valid, input logic use_src,
                                        input logic [REG_AW-1:0] src,
                                        input wr_slot_t mem, input wr_slot_t wb);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (ex_valid && use_src) begin
      if (slot_supplies(mem, src))     sel = FWD_MEM;
      else if (slot_supplies(wb, src)) sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    w_fwd_a = pick_src(r_ex.valid, r_ex.use_rs1, r_ex.rs1, r_mem, r_wb);
    w_fwd_b = pick_src(r_ex.valid, r_ex.use_rs2, r_ex.rs2, r_mem, r_wb);
  end

  assign fwd_a = w_fwd_a;
  assign fwd_b = w_fwd_b;

  // A load still in EX cannot feed the instruction in ID; flush suppresses the stall.
  always_comb begin
    w_rs1_hit     = id_use_rs1 && (id_rs1 == r_ex.rd);
    w_rs2_hit     = id_use_rs2 && (id_rs2 == r_ex.rd);
    w_load_hazard = r_ex.valid && r_ex.mem_read && (r_ex.rd != '0) && (w_rs1_hit || w_rs2_hit);
    stall         = id_valid && !flush && w_load_hazard;
  end

  always_comb begin
    // NOTE: default every field first so no path leaves w_ex_next unassigned (no latch).
    w_ex_next = '0;
    if (id_valid && !stall && !flush) begin
      w_ex_next.valid     = 1'b1;
      w_ex_next.rs1       = id_rs1;
      w_ex_next.rs2       = id_rs2;
      w_ex_next.use_rs1   = id_use_rs1;
      w_ex_next.use_rs2   = id_use_rs2;
      w_ex_next.rd        = id_rd;
      w_ex_next.reg_write = id_reg_write;
      w_ex_next.mem_read  = id_mem_read;
    end
  end

  // NOTE: every slot is reset, so an asserted rst_n drops all in-flight hazards at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex          <= '0;
      r_mem         <= '0;
      r_wb          <= '0;
      r_stall_count <= '0;
    end else begin
      // NOTE: non-blocking updates let WB<=MEM and MEM<=EX both see pre-edge values.
      r_wb            <= r_mem;
      r_mem.valid     <= r_ex.valid;
      r_mem.rd        <= r_ex.rd;
      r_mem.reg_write <= r_ex.reg_write;
      r_ex            <= w_ex_next;
      if (stall && (r_stall_count != '1))
        r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_fwd_sel_unit.sv
// Scoreboard bench for fwd_sel_unit: a driver predicts each cycle's outputs from an
// instruction-history model, and a negedge monitor compares them with two DUT instances.
module tb_fwd_sel_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic [1:0]  fwd_a, fwd_b, fwd_a_s, fwd_b_s;
  logic        stall, stall_s;
  logic [31:0] stall_count;
  logic [3:0]  stall_count_s;

  always #5 clk = ~clk;

  fwd_sel_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .stall_count(stall_count)
  );

  fwd_sel_unit #(.REG_AW(5), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a(fwd_a_s), .fwd_b(fwd_b_s), .stall(stall_s), .stall_count(stall_count_s)
  );

  typedef struct {
    logic       valid;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       rw, mr;
  } instr_t;

  typedef struct {
    logic [1:0]  fa, fb;
    logic        st;
    logic [31:0] cnt;
    logic [3:0]  cnt_sat;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  instr_t hist[3];   // hist[0]: instruction now in EX, [1]: one older, [2]: two older
  longint model_cnt;
  int     checks   = 0;
  int     failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t bubble();
    instr_t b;
    b.valid = 1'b0; b.rs1 = '0; b.rs2 = '0; b.u1 = 1'b0; b.u2 = 1'b0;
    b.rd = '0; b.rw = 1'b0; b.mr = 1'b0;
    return b;
  endfunction

  function automatic instr_t mk_alu(input int rd, input int rs1, input int rs2);
    instr_t i;
    i.valid = 1'b1; i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.u1 = 1'b1; i.u2 = 1'b1;
    i.rd = 5'(rd); i.rw = 1'b1; i.mr = 1'b0;
    return i;
  endfunction

  function automatic instr_t mk_load(input int rd, input int rs1);
    instr_t i;
    i = mk_alu(rd, rs1, 0);
    i.u2 = 1'b0; i.mr = 1'b1;
    return i;
  endfunction

  function automatic instr_t mk_lui(input int rd, input int rs1_field);
    instr_t i;
    i = mk_alu(rd, rs1_field, rs1_field);
    i.u1 = 1'b0; i.u2 = 1'b0;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.valid = ($urandom_range(0, 9) != 0);
    i.rs1   = 5'($urandom_range(0, 7));
    i.rs2   = 5'($urandom_range(0, 7));
    i.u1    = ($urandom_range(0, 3) != 0);
    i.u2    = ($urandom_range(0, 1) != 0);
    i.rd    = 5'($urandom_range(0, 7));
    i.rw    = ($urandom_range(0, 4) != 0);
    i.mr    = i.rw && ($urandom_range(0, 2) == 0);
    return i;
  endfunction

  // Operand comes from the most recent older instruction that writes a non-zero src.
  function automatic logic [1:0] model_fwd(input logic use_src, input logic [4:0] src);
    if (!hist[0].valid || !use_src || src == 5'd0) return 2'b00;
    for (int age = 1; age <= 2; age++)
      if (hist[age].valid && hist[age].rw && hist[age].rd == src)
        return (age == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  // One clock cycle: present ins, predict this cycle's outputs, then advance the model.
  task automatic drive(input instr_t ins, input logic fl, input logic rst_v, output logic st);
    exp_t e;
    logic hazard;
    id_valid = ins.valid; id_rs1 = ins.rs1; id_rs2 = ins.rs2; id_use_rs1 = ins.u1;
    id_use_rs2 = ins.u2; id_rd = ins.rd; id_reg_write = ins.rw; id_mem_read = ins.mr;
    flush = fl; rst_n = rst_v;
    if (!rst_v) begin
      for (int k = 0; k < 3; k++) hist[k] = bubble();
      model_cnt = 0;
    end
    hazard = hist[0].valid && hist[0].mr && hist[0].rd != 5'd0 &&
             ((ins.u1 && ins.rs1 == hist[0].rd) || (ins.u2 && ins.rs2 == hist[0].rd));
    st = rst_v && ins.valid && !fl && hazard;
    e.fa      = model_fwd(hist[0].u1, hist[0].rs1);
    e.fb      = model_fwd(hist[0].u2, hist[0].rs2);
    e.st      = st;
    e.cnt     = model_cnt[31:0];
    e.cnt_sat = (model_cnt > 15) ? 4'd15 : model_cnt[3:0];
    sb_q.push_back(e);
    @(posedge clk);
    if (rst_v) begin
      if (st && model_cnt < 64'h0000_0000_FFFF_FFFF) model_cnt++;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = (ins.valid && !st && !fl) ? ins : bubble();
    end
    #1;
  endtask

  // Issue like a front end would: a stalled instruction is re-presented until it enters EX.
  task automatic issue(input instr_t ins);
    logic st;
    int   n;
    n = 0;
    drive(ins, 1'b0, 1'b1, st);
    while (st && n < 4) begin
      drive(ins, 1'b0, 1'b1, st);
      n++;
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("fwd_a", 32'(fwd_a), 32'(mon_e.fa));
      check("fwd_b", 32'(fwd_b), 32'(mon_e.fb));
      check("stall", 32'(stall), 32'(mon_e.st));
      check("stall_count", stall_count, mon_e.cnt);
      check("fwd_a_cnt4", 32'(fwd_a_s), 32'(mon_e.fa));
      check("fwd_b_cnt4", 32'(fwd_b_s), 32'(mon_e.fb));
      check("stall_cnt4", 32'(stall_s), 32'(mon_e.st));
      check("stall_count_sat", 32'(stall_count_s), 32'(mon_e.cnt_sat));
    end
  end

  initial begin
    logic   st;
    instr_t r;
    rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    for (int k = 0; k < 3; k++) hist[k] = bubble();
    model_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    repeat (2) drive(mk_alu(1, 1, 1), 1'b0, 1'b0, st);

    // Back-to-back dependency, then with one independent instruction between.
    issue(mk_alu(5, 1, 2)); issue(mk_alu(6, 5, 7)); issue(bubble()); issue(bubble());
    issue(mk_alu(5, 1, 2)); issue(mk_alu(11, 2, 3)); issue(mk_alu(6, 5, 7));
    issue(bubble()); issue(bubble());
    // Both MEM and WB write x5.
    issue(mk_alu(5, 1, 2)); issue(mk_alu(5, 3, 4)); issue(mk_alu(10, 5, 5));
    issue(bubble()); issue(bubble());
    // Load-use pair.
    issue(mk_load(8, 2)); issue(mk_alu(9, 8, 8)); issue(bubble()); issue(bubble());
    // Loads to x0 and unused source fields.
    issue(mk_load(0, 1)); issue(mk_alu(1, 0, 0)); issue(bubble());
    issue(mk_alu(4, 1, 2)); issue(mk_lui(3, 4)); issue(bubble()); issue(bubble());
    // Flush arrives in the would-be stall cycle.
    issue(mk_load(8, 2)); drive(mk_alu(9, 8, 8), 1'b1, 1'b1, st);
    issue(bubble()); issue(bubble());

    for (int c = 0; c < 400; c++) begin
      r = rand_instr();
      if (c >= 200 && c < 203) drive(r, 1'b0, 1'b0, st);
      else if ($urandom_range(0, 9) == 0) drive(r, 1'b1, 1'b1, st);
      else issue(r);
    end

    // Fresh counters, then 20 load-use stalls to push the 4-bit counter past its limit.
    repeat (2) drive(bubble(), 1'b0, 1'b0, st);
    repeat (20) begin
      issue(mk_load(1, 2));
      issue(mk_alu(2, 1, 1));
    end
    issue(bubble()); issue(bubble());

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
